// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter (keyboard emulation).
// Scan-code bytes enter through a valid/ready FIFO and are serialised as
// 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop) on
// generated PS2_CLK / PS2_DAT lines. Host inhibit aborts a frame in flight
// and the same byte is resent from its start bit after an idle gap.

module ps2_device_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned PS2_FREQ_HZ = 12500,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned GAP_HALVES  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [7:0]                    DIN,
  input  logic                          DIN_VALID,
  output logic                          DIN_READY,
  input  logic                          INHIBIT,
  output logic                          PS2_CLK,
  output logic                          PS2_DAT,
  output logic                          BUSY,
  output logic                          FRAME_DONE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  // Half-period and gap lengths in system clock cycles.
  localparam int unsigned H       = CLK_FREQ_HZ / (2 * PS2_FREQ_HZ);
  localparam int unsigned G       = GAP_HALVES * H;
  localparam int unsigned CNT_TOP = (G > H) ? G : H;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW     = AW + 1;

  // FSM state encodings.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BIT_HIGH = 3'd1;
  localparam logic [2:0] S_BIT_LOW  = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_ABORT    = 3'd4;

  // FSM / serialiser registers.
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;
  logic [10:0]   r_frame;
  logic          r_ps2_clk;
  logic          r_ps2_dat;
  logic          r_frame_done;

  // FIFO registers.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Derived control.
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [7:0]    w_head;
  logic [10:0]   w_head_frame;
  logic          w_start;
  logic          w_half_end;
  logic          w_gap_end;
  logic          w_last_bit;
  logic [3:0]    w_next_idx;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FCW'(FIFO_DEPTH));
  assign w_push       = DIN_VALID && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  // Frame bit order on the wire is frame[0] first: start, D0..D7, parity, stop.
  assign w_head_frame = {1'b1, ~^w_head, w_head, 1'b0};
  assign w_start      = !w_empty && !INHIBIT;
  assign w_half_end   = (r_cnt == CW'(H - 1));
  assign w_gap_end    = (r_cnt == CW'(G - 1));
  assign w_last_bit   = (r_bit_idx == 4'd10);
  assign w_next_idx   = r_bit_idx + 4'd1;
  // The head byte is released only once its stop bit has fully completed.
  assign w_pop        = (r_state == S_BIT_LOW) && w_last_bit && w_half_end;

  assign DIN_READY  = !w_full;
  assign PS2_CLK    = r_ps2_clk;
  assign PS2_DAT    = r_ps2_dat;
  assign FRAME_DONE = r_frame_done;
  assign FIFO_COUNT = r_count;
  assign BUSY       = (r_state != S_IDLE) || !w_empty;

  // FIFO storage write; contents need no reset since pointers/count do.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DIN;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^AW).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame sequencer: drives registered PS/2 lines and the done pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_frame      <= '1;
      r_ps2_clk    <= 1'b1;
      r_ps2_dat    <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ps2_clk <= 1'b1;
          r_ps2_dat <= 1'b1;
          if (w_start) begin
            r_state   <= S_BIT_HIGH;
            r_frame   <= w_head_frame;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_ps2_dat <= w_head_frame[0];
          end
        end

        S_BIT_HIGH: begin
          if (INHIBIT) begin
            r_state   <= S_ABORT;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_ps2_clk <= 1'b1;
            r_ps2_dat <= 1'b1;
          end else if (w_half_end) begin
            r_state   <= S_BIT_LOW;
            r_cnt     <= '0;
            r_ps2_clk <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BIT_LOW: begin
          if (INHIBIT && !w_last_bit) begin
            r_state   <= S_ABORT;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_ps2_clk <= 1'b1;
            r_ps2_dat <= 1'b1;
          end else if (w_half_end) begin
            r_cnt     <= '0;
            r_ps2_clk <= 1'b1;
            if (w_last_bit) begin
              r_state      <= S_GAP;
              r_ps2_dat    <= 1'b1;
              r_frame_done <= 1'b1;
            end else begin
              r_state   <= S_BIT_HIGH;
              r_bit_idx <= w_next_idx;
              r_ps2_dat <= r_frame[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // The next frame is launched straight from the final gap cycle so
        // the lines stay high for exactly G cycles between frames, instead
        // of G plus one IDLE cycle.
        S_GAP: begin
          r_ps2_clk <= 1'b1;
          r_ps2_dat <= 1'b1;
          if (w_gap_end) begin
            r_cnt <= '0;
            if (w_start) begin
              r_state   <= S_BIT_HIGH;
              r_frame   <= w_head_frame;
              r_bit_idx <= '0;
              r_ps2_dat <= w_head_frame[0];
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_ABORT: begin
          r_ps2_clk <= 1'b1;
          r_ps2_dat <= 1'b1;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!INHIBIT) begin
            r_state <= S_GAP;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_ps2_clk <= 1'b1;
          r_ps2_dat <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx with H=5 (1 MHz / 100 kHz), gap 20.
module tb_ps2_device_tx;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic       INHIBIT;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       BUSY;
  logic       FRAME_DONE;
  logic [2:0] FIFO_COUNT;

  ps2_device_tx #(
    .CLK_FREQ_HZ(1000000),
    .PS2_FREQ_HZ(100000),
    .FIFO_DEPTH (4),
    .GAP_HALVES (4)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .INHIBIT   (INHIBIT),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE),
    .FIFO_COUNT(FIFO_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] din;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  int n_vec  = 0;
  int n_fail = 0;

  // Line monitor state (updated only from step()).
  int          cyc = 0;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;
  int          fall_idx = 0;
  logic [10:0] cur_bits = '0;
  int          total_falls = 0;
  int          done_total = 0;
  int          starts = 0;
  int          start_cyc = 0;
  int          fall_lat = 0;
  int          last_len = 0;
  int          hi_run = 0;
  int          peak = 0;
  logic [10:0] frames[$];
  int          gaps[$];

  int f0, d0, s0, b;

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    if (prev_clk && prev_dat && PS2_CLK && !PS2_DAT) begin
      start_cyc = cyc;
      fall_idx  = 0;
      starts++;
      gaps.push_back(hi_run);
    end
    if (prev_clk && !PS2_CLK) begin
      if (fall_idx < 11) cur_bits[fall_idx] = PS2_DAT;
      if (fall_idx == 0) fall_lat = cyc - start_cyc;
      fall_idx++;
      total_falls++;
    end
    if (PS2_CLK && PS2_DAT) hi_run++;
    else hi_run = 0;
    if (FRAME_DONE) begin
      done_total++;
      frames.push_back(cur_bits);
      last_len = cyc - start_cyc;
    end
    if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
    prev_clk = PS2_CLK;
    prev_dat = PS2_DAT;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic wait_falls(input int target, input int budget);
    int n = 0;
    while (total_falls < target && n < budget) begin
      step();
      n++;
    end
    check("falls_timeout", 32'(total_falls >= target), 32'd1);
  endtask

  task automatic push1(input logic [7:0] d);
    DIN = d;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic p);
    logic [10:0] got;
    if (frames.size() == 0) begin
      check({name, "_missing"}, 32'(frames.size()), 32'd1);
    end else begin
      got = frames.pop_front();
      check(name, 32'(got), 32'(frame_of(d, p)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Hand-computed odd parity for each byte.
    vecs[0] = '{din: 8'h1C, par: 1'b0};
    vecs[1] = '{din: 8'hF0, par: 1'b1};
    vecs[2] = '{din: 8'h76, par: 1'b0};
    vecs[3] = '{din: 8'h00, par: 1'b1};
    vecs[4] = '{din: 8'hFF, par: 1'b1};
    vecs[5] = '{din: 8'h01, par: 1'b0};
    vecs[6] = '{din: 8'h80, par: 1'b0};
    vecs[7] = '{din: 8'hA5, par: 1'b1};

    RESET_N   = 1'b0;
    DIN       = '0;
    DIN_VALID = 1'b0;
    INHIBIT   = 1'b0;
    repeat (3) step();
    check("rst_clk",   32'(PS2_CLK),    32'd1);
    check("rst_dat",   32'(PS2_DAT),    32'd1);
    check("rst_done",  32'(FRAME_DONE), 32'd0);
    check("rst_busy",  32'(BUSY),       32'd0);
    check("rst_count", 32'(FIFO_COUNT), 32'd0);
    check("rst_ready", 32'(DIN_READY),  32'd1);
    RESET_N = 1'b1;
    repeat (2) step();

    // Single frames from the vector table.
    for (int i = 0; i < 8; i++) begin
      f0 = total_falls;
      d0 = done_total;
      push1(vecs[i].din);
      check("count_after_push", 32'(FIFO_COUNT), 32'd1);
      step();
      check("start_dat", 32'(PS2_DAT), 32'd0);
      check("start_clk", 32'(PS2_CLK), 32'd1);
      wait_idle(400);
      check("fall_count", 32'(total_falls - f0), 32'd11);
      check("done_count", 32'(done_total - d0), 32'd1);
      check_frame("frame_bits", vecs[i].din, vecs[i].par);
      check("frame_len", 32'(last_len), 32'd110);
      check("first_fall_lat", 32'(fall_lat), 32'd5);
      check("idle_lines", 32'({PS2_CLK, PS2_DAT}), 32'd3);
      check("idle_count", 32'(FIFO_COUNT), 32'd0);
    end

    // Three back-to-back bytes: order, parity, exact gaps, peak occupancy.
    f0 = total_falls;
    d0 = done_total;
    peak = 0;
    gaps.delete();
    DIN_VALID = 1'b1;
    DIN = 8'h1C; step();
    DIN = 8'hF0; step();
    DIN = 8'h1C; step();
    DIN_VALID = 1'b0;
    wait_idle(1000);
    check("b2b_done", 32'(done_total - d0), 32'd3);
    check("b2b_falls", 32'(total_falls - f0), 32'd33);
    check_frame("b2b_f0", 8'h1C, 1'b0);
    check_frame("b2b_f1", 8'hF0, 1'b1);
    check_frame("b2b_f2", 8'h1C, 1'b0);
    check("b2b_starts", 32'(gaps.size()), 32'd3);
    if (gaps.size() == 3) begin
      check("b2b_gap1", 32'(gaps[1]), 32'd20);
      check("b2b_gap2", 32'(gaps[2]), 32'd20);
    end
    check("b2b_peak", 32'(peak), 32'd3);

    // Fill the FIFO while inhibited; fifth byte waits for the first pop.
    f0 = total_falls;
    d0 = done_total;
    s0 = starts;
    INHIBIT = 1'b1;
    push1(8'h11);
    push1(8'h23);
    push1(8'h33);
    check("full_ready_pre", 32'(DIN_READY), 32'd1);
    push1(8'h07);
    check("full_ready", 32'(DIN_READY), 32'd0);
    check("full_count", 32'(FIFO_COUNT), 32'd4);
    DIN = 8'h55;
    DIN_VALID = 1'b1;
    repeat (30) step();
    check("full_hold_count", 32'(FIFO_COUNT), 32'd4);
    check("inh_no_falls", 32'(total_falls - f0), 32'd0);
    check("inh_no_starts", 32'(starts - s0), 32'd0);
    check("inh_busy", 32'(BUSY), 32'd1);
    INHIBIT = 1'b0;
    b = 0;
    while (!DIN_READY && b < 400) begin
      step();
      b++;
    end
    check("fifth_ready", 32'(DIN_READY), 32'd1);
    check("fifth_after_pop", 32'(done_total - d0), 32'd1);
    step();
    DIN_VALID = 1'b0;
    check("fifth_count", 32'(FIFO_COUNT), 32'd4);
    wait_idle(2000);
    check("full_done", 32'(done_total - d0), 32'd5);
    check_frame("full_f0", 8'h11, 1'b1);
    check_frame("full_f1", 8'h23, 1'b0);
    check_frame("full_f2", 8'h33, 1'b1);
    check_frame("full_f3", 8'h07, 1'b0);
    check_frame("full_f4", 8'h55, 1'b1);

    // Inhibit after the 4th fall: abort, then full retransmit of 0x76.
    f0 = total_falls;
    d0 = done_total;
    push1(8'h76);
    wait_falls(f0 + 4, 200);
    INHIBIT = 1'b1;
    step();
    check("abort_lines", 32'({PS2_CLK, PS2_DAT}), 32'd3);
    repeat (29) step();
    check("abort_no_done", 32'(done_total - d0), 32'd0);
    check("abort_falls", 32'(total_falls - f0), 32'd4);
    check("abort_count", 32'(FIFO_COUNT), 32'd1);
    INHIBIT = 1'b0;
    gaps.delete();
    wait_idle(600);
    check("retx_done", 32'(done_total - d0), 32'd1);
    check("retx_falls", 32'(total_falls - f0), 32'd15);
    check_frame("retx_frame", 8'h76, 1'b0);
    check("retx_len", 32'(last_len), 32'd110);
    check("retx_starts", 32'(gaps.size()), 32'd1);
    if (gaps.size() == 1) check("retx_high_run", 32'(gaps[0]), 32'd50);

    // Inhibit during the stop-bit low phase is ignored.
    f0 = total_falls;
    d0 = done_total;
    push1(8'hF0);
    wait_falls(f0 + 11, 300);
    INHIBIT = 1'b1;
    b = 0;
    while (done_total == d0 && b < 20) begin
      step();
      b++;
    end
    check("stop_inh_done", 32'(done_total - d0), 32'd1);
    check("stop_inh_pop", 32'(FIFO_COUNT), 32'd0);
    check_frame("stop_inh_frame", 8'hF0, 1'b1);
    step();
    check("done_pulse_width", 32'(FRAME_DONE), 32'd0);
    INHIBIT = 1'b0;
    wait_idle(100);

    // Asynchronous reset mid-frame with two bytes queued.
    f0 = total_falls;
    d0 = done_total;
    DIN_VALID = 1'b1;
    DIN = 8'hAA; step();
    DIN = 8'hBB; step();
    DIN_VALID = 1'b0;
    wait_falls(f0 + 3, 200);
    RESET_N = 1'b0;
    #1;
    check("arst_clk",   32'(PS2_CLK),    32'd1);
    check("arst_dat",   32'(PS2_DAT),    32'd1);
    check("arst_count", 32'(FIFO_COUNT), 32'd0);
    check("arst_busy",  32'(BUSY),       32'd0);
    repeat (3) step();
    RESET_N = 1'b1;
    s0 = starts;
    f0 = total_falls;
    repeat (200) step();
    check("post_rst_starts", 32'(starts - s0), 32'd0);
    check("post_rst_falls", 32'(total_falls - f0), 32'd0);
    check("post_rst_done", 32'(done_total - d0), 32'd0);
    check("post_rst_busy", 32'(BUSY), 32'd0);
    frames.delete();
    push1(8'h1C);
    wait_idle(400);
    check("post_rst_frame_done", 32'(done_total - d0), 32'd1);
    check_frame("post_rst_frame", 8'h1C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
